// File: rtl/mb_rtu_pkg.sv
// Shared types and gap constants for the RTU transmit gap controller.
package mb_rtu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_GAP,
    S_FETCH,
    S_SEND,
    S_WAIT_DONE,
    S_POST_GAP
  } state_e;

  // Gap lengths in bit ticks: 1.5 and 3.5 character times of 10 bits each.
  localparam int GAP_15_TICKS = 15;
  localparam int GAP_35_TICKS = 35;
  localparam int SIL_W        = 6;

endpackage

// File: rtl/mb_bit_tick.sv
// Bit-period tick generator; clr_i restarts the period so silence is
// measured from the exact end of the last byte.
module mb_bit_tick #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr_i,
  output logic tick_o
);
  localparam int BPS = (CLK_FREQ / BAUD_RATE < 1) ? 1 : CLK_FREQ / BAUD_RATE;
  localparam int CW  = (BPS > 1) ? $clog2(BPS) : 1;

  logic [CW-1:0] cnt_q;
  logic          wrap;

  assign wrap   = (cnt_q == CW'(BPS - 1));
  assign tick_o = wrap;

  // Free-running divider, restarted on clear.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)              cnt_q <= '0;
    else if (clr_i || wrap)  cnt_q <= '0;
    else                     cnt_q <= cnt_q + CW'(1);
  end
endmodule

// File: rtl/mb_tx_gap_ctrl.sv
// Frame sequencer for an RTU transmitter: enforces 3.5T silence around each
// frame and aborts when the inter-byte gap reaches 1.5T.
module mb_tx_gap_ctrl
  import mb_rtu_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       frame_start,
  input  logic [7:0] frame_len,
  input  logic [7:0] tx_data_in,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       uart_tx_start,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_done,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       frame_err
);
  state_e           state_q;
  logic [SIL_W-1:0] sil_q, sil_d;
  logic [7:0]       rem_q;
  logic [7:0]       data_q;
  logic             first_q, abort_q;
  logic             start_q, busy_q, done_q, err_q;
  logic             tick;
  logic             sil_35, sil_15;

  mb_bit_tick #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tick (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr_i  (uart_tx_done),
    .tick_o (tick)
  );

  assign sil_35 = (sil_q == SIL_W'(GAP_35_TICKS));
  assign sil_15 = (sil_q >= SIL_W'(GAP_15_TICKS));

  // Line silence in bit ticks since the last byte finished, saturating at 3.5T.
  always_comb begin
    sil_d = sil_q;
    if (uart_tx_done)          sil_d = '0;
    else if (tick && !sil_35)  sil_d = sil_q + SIL_W'(1);
  end

  // Silence register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) sil_q <= '0;
    else        sil_q <= sil_d;
  end

  // Frame FSM with registered pulse/level outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
      abort_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            if (frame_len == 8'd0) begin
              err_q <= 1'b1;
            end else begin
              rem_q   <= frame_len;
              first_q <= 1'b1;
              abort_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_PRE_GAP;
            end
          end
        end
        S_PRE_GAP: if (sil_35) state_q <= S_FETCH;
        S_FETCH: begin
          // A late byte inside a frame would split it on the wire: give up.
          if (!first_q && sil_15) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            abort_q <= 1'b1;
            state_q <= S_POST_GAP;
          end else if (tx_data_valid) begin
            data_q  <= tx_data_in;
            start_q <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: state_q <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (uart_tx_done) begin
            first_q <= 1'b0;
            rem_q   <= rem_q - 8'd1;
            state_q <= (rem_q == 8'd1) ? S_POST_GAP : S_FETCH;
          end
        end
        S_POST_GAP: begin
          if (sil_35) begin
            if (!abort_q) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
            abort_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data_ready = (state_q == S_FETCH);
  assign uart_tx_start = start_q;
  assign uart_tx_data  = data_q;
  assign frame_busy    = busy_q;
  assign frame_done    = done_q;
  assign frame_err     = err_q;
endmodule

// File: doc/mb_tx_gap_ctrl.md
MB_TX_GAP_CTRL -- requirements
Module: mb_tx_gap_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 SHALL have clk_in  input  1  system clock; one clock domain, all logic on rising edge.
REQ-004 SHALL have rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have frame_start  input  1  one-cycle pulse requesting a frame of frame_len bytes.
REQ-006 SHALL have frame_len  input  8  byte count, sampled on frame_start.
REQ-007 SHALL have tx_data_in  input  8  next frame byte from upstream buffer.
REQ-008 SHALL have tx_data_valid  input  1  tx_data_in valid.
REQ-009 SHALL have tx_data_ready  output  1  byte accepted when valid and ready are both high in a cycle.
REQ-010 SHALL have uart_tx_start  output  1  one-cycle pulse starting the byte UART transmitter.
REQ-011 SHALL have uart_tx_data  output  8  byte for the UART, held stable from start to done.
REQ-012 SHALL have uart_tx_done  input  1  one-cycle pulse: UART finished the byte, stop bit included.
REQ-013 SHALL have frame_busy  output  1  high from accepted frame_start until frame_done/frame_err.
REQ-014 SHALL have frame_done  output  1  one-cycle pulse: frame sent and trailing 3.5T silence elapsed.
REQ-015 SHALL have frame_err  output  1  one-cycle pulse: frame rejected or aborted.

Function
REQ-016 SHALL derive a bit tick every BPS=CLK_FREQ/BAUD_RATE cycles; 1T=10 bit times, 1.5T=15 ticks, 3.5T=35 ticks.
REQ-017 SHALL run a silence counter that clears on reset and on uart_tx_done, counts bit ticks, saturates at 35.
REQ-018 SHALL implement states IDLE, PRE_GAP, FETCH, SEND, WAIT_DONE, POST_GAP.
REQ-019 IDLE: frame_start with frame_len>0 latches length, sets frame_busy next cycle, goes to PRE_GAP.
REQ-020 IDLE: frame_start with frame_len=0 pulses frame_err next cycle and stays IDLE, frame_busy low.
REQ-021 frame_start outside IDLE SHALL be ignored, with no error and no state change.
REQ-022 PRE_GAP SHALL wait until the silence counter is 35, then go to FETCH; no wait if already 35.
REQ-023 FETCH SHALL drive tx_data_ready high; on handshake, latch byte into uart_tx_data, go to SEND.
REQ-024 SEND SHALL pulse uart_tx_start for exactly one cycle (cycle after handshake), then go to WAIT_DONE.
REQ-025 WAIT_DONE: on uart_tx_done, decrement remaining count; if zero go to POST_GAP, else go to FETCH.
REQ-026 FETCH for a non-first byte: if silence counter reaches 15 before handshake, abort.
REQ-027 Abort SHALL pulse frame_err, drop frame_busy the same cycle, go to POST_GAP without frame_done.
REQ-028 POST_GAP SHALL wait until silence counter is 35; in a normal frame pulse frame_done, drop frame_busy, go to IDLE.
REQ-029 POST_GAP after an abort SHALL return to IDLE silently when silence reaches 35.
REQ-030 tx_data_ready SHALL be high only in FETCH; no byte SHALL be consumed outside FETCH.
REQ-031 Byte counter: 8 bits, no wrap; frame_len=255 sends exactly 255 bytes.

Reset
REQ-032 On rst_in all outputs SHALL be 0, state IDLE, silence counter 0, byte counter 0, bit tick counter 0.
REQ-033 A mid-frame reset SHALL abort immediately without frame_err or frame_done; the next frame waits a full 3.5T.

Structure
REQ-034 Package mb_rtu_pkg SHALL hold the state enum and constants GAP_15_TICKS=15 and GAP_35_TICKS=35.
REQ-035 The bit tick generator SHALL be sub-module mb_bit_tick (params CLK_FREQ, BAUD_RATE; output tick pulse).

Verification (CLK_FREQ=1000, BAUD_RATE=100, BPS=10 cycles)
REQ-036 Reset, frame_start with len=3, bytes always valid -> first uart_tx_start about 350 cycles after reset; 3 starts with data order preserved; frame_done about 350 cycles after last done.
REQ-037 Back-to-back frames: second frame_start 1 cycle after frame_done -> first uart_tx_start of frame 2 at least 350 cycles after last done of frame 1.
REQ-038 len=2, byte 2 valid 200 cycles after byte 1 done -> frame_err near 150 cycles; no second uart_tx_start; no frame_done.
REQ-039 frame_start with len=0 -> frame_err 1 cycle later; frame_busy stays 0; frame_start during busy ignored.
REQ-040 rst_in asserted in WAIT_DONE -> all outputs 0 next edge; a new frame waits 350 cycles before its first start.
